// File: rtl/cnt_share_array_gen.sv
// Shared counter with TDIM retiming pipelines, each fanning out to SDIM taps.
// Core count and its roll-over flag travel together down every pipeline.
module cnt_share_array_gen #(
   parameter int CWID   = 10,
   parameter int CMAX   = 2**CWID-1,
   parameter int MODE   = 0,
   parameter int BDIM   = 1,
   parameter int TDIM   = (BDIM < 1) ? 1 : BDIM,
   parameter int SDIM   = 16,
   parameter int PDEPTH = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        clear,
   output logic [CWID-1:0]             cntCore,
   output logic [TDIM*SDIM*CWID-1:0]   cntSeq,
   output logic [TDIM-1:0]             wrapSeq
);

   localparam int SW = CWID + 1;
   localparam logic [CWID-1:0] TERM  = CWID'(CMAX);
   localparam logic [CWID-1:0] START = (MODE != 0) ? TERM : '0;

   if (CMAX == 0 || CMAX > 2**CWID-1) begin : g_bad_cmax
      $error("cnt_share_array_gen: CMAX out of range 1..2**CWID-1");
   end

   logic [CWID-1:0] cnt_q, cnt_d;
   logic            wrap_q, wrap_d;

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (clear) begin
         cnt_d = START;
      end else if (enable) begin
         if (MODE == 0) begin
            wrap_d = (cnt_q == TERM);
            cnt_d  = wrap_d ? '0 : cnt_q + CWID'(1);
         end else begin
            wrap_d = (cnt_q == '0);
            cnt_d  = wrap_d ? TERM : cnt_q - CWID'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= START;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign cntCore = cnt_q;

   for (genvar i = 0; i < TDIM; i++) begin : g_buf
      logic [CWID-1:0] tail_cnt;
      logic            tail_wrap;

      if (PDEPTH == 0) begin : g_wire
         assign tail_cnt  = cnt_q;
         assign tail_wrap = wrap_q;
      end else begin : g_pipe
         logic [SW-1:0] pipe_q [PDEPTH];
         logic [SW-1:0] pipe_d [PDEPTH];

         // Stages shift every cycle regardless of enable/clear
         always_comb begin
            pipe_d[0] = {cnt_q, wrap_q};
            for (int s = 1; s < PDEPTH; s++) begin
               pipe_d[s] = pipe_q[s-1];
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int s = 0; s < PDEPTH; s++) begin
                  pipe_q[s] <= {START, 1'b0};
               end
            end else begin
               for (int s = 0; s < PDEPTH; s++) begin
                  pipe_q[s] <= pipe_d[s];
               end
            end
         end

         assign tail_cnt  = pipe_q[PDEPTH-1][SW-1:1];
         assign tail_wrap = pipe_q[PDEPTH-1][0];
      end

      assign wrapSeq[i] = tail_wrap;

      for (genvar j = 0; j < SDIM; j++) begin : g_tap
         assign cntSeq[(i*SDIM+j)*CWID +: CWID] = tail_cnt;
      end
   end

endmodule

// File: tb/tb_cnt_share_array_gen.sv
// Random and directed stimulus on four configurations of cnt_share_array_gen,
// checked against a modulo-arithmetic model with a history queue per config.
module tb_cnt_share_array_gen;

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic clear;

   always #5 clk = ~clk;

   // A: up, CMAX 9, depth 1; B: down, CMAX 9; C: 2x4 taps, depth 3; D: wire
   logic [3:0]  core_a;  logic [63:0] seq_a;  logic [0:0] wrap_a;
   logic [3:0]  core_b;  logic [63:0] seq_b;  logic [0:0] wrap_b;
   logic [9:0]  core_c;  logic [79:0] seq_c;  logic [1:0] wrap_c;
   logic [2:0]  core_d;  logic [47:0] seq_d;  logic [0:0] wrap_d;

   cnt_share_array_gen #(.CWID(4), .CMAX(9), .MODE(0), .BDIM(1),
      .SDIM(16), .PDEPTH(1)) u_a (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .cntCore(core_a), .cntSeq(seq_a), .wrapSeq(wrap_a));

   cnt_share_array_gen #(.CWID(4), .CMAX(9), .MODE(1), .BDIM(1),
      .SDIM(16), .PDEPTH(1)) u_b (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .cntCore(core_b), .cntSeq(seq_b), .wrapSeq(wrap_b));

   cnt_share_array_gen #(.CWID(10), .MODE(0), .BDIM(2),
      .SDIM(4), .PDEPTH(3)) u_c (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .cntCore(core_c), .cntSeq(seq_c), .wrapSeq(wrap_c));

   cnt_share_array_gen #(.CWID(3), .CMAX(7), .MODE(0), .BDIM(0),
      .SDIM(16), .PDEPTH(0)) u_d (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .cntCore(core_d), .cntSeq(seq_d), .wrapSeq(wrap_d));

   localparam int MODE_P [4] = '{0, 1, 0, 0};
   localparam int CMAX_P [4] = '{9, 9, 1023, 7};
   localparam int DEP_P  [4] = '{1, 1, 3, 0};
   localparam int NT_P   [4] = '{1, 1, 2, 1};
   localparam int NS_P   [4] = '{16, 16, 4, 16};

   int n_vec = 0;
   int n_err = 0;

   int hc [4][$];
   int hw [4][$];

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic int start_of(input int k);
      return (MODE_P[k] != 0) ? CMAX_P[k] : 0;
   endfunction

   function automatic int obs_core(input int k);
      case (k)
         0: return int'(core_a);
         1: return int'(core_b);
         2: return int'(core_c);
         default: return int'(core_d);
      endcase
   endfunction

   function automatic int obs_tap(input int k, input int j);
      case (k)
         0: return int'(seq_a[j*4 +: 4]);
         1: return int'(seq_b[j*4 +: 4]);
         2: return int'(seq_c[j*10 +: 10]);
         default: return int'(seq_d[j*3 +: 3]);
      endcase
   endfunction

   function automatic int obs_wrap(input int k, input int b);
      case (k)
         0: return int'(wrap_a[b]);
         1: return int'(wrap_b[b]);
         2: return int'(wrap_c[b]);
         default: return int'(wrap_d[b]);
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         hc[k].delete();
         hw[k].delete();
         for (int s = 0; s <= DEP_P[k]; s++) begin
            hc[k].push_back(start_of(k));
            hw[k].push_back(0);
         end
      end
   endtask

   // hc[k][d] is the core value d cycles ago
   task automatic model_step(input logic en, input logic cl);
      int c, w, p;
      for (int k = 0; k < 4; k++) begin
         c = hc[k][0];
         p = CMAX_P[k] + 1;
         w = 0;
         if (cl) begin
            c = start_of(k);
         end else if (en) begin
            if (MODE_P[k] == 0) c = (c + 1) % p;
            else                c = (c + p - 1) % p;
            w = (c == start_of(k)) ? 1 : 0;
         end
         hc[k].push_front(c);
         hw[k].push_front(w);
         void'(hc[k].pop_back());
         void'(hw[k].pop_back());
      end
   endtask

   task automatic check_all();
      int d;
      for (int k = 0; k < 4; k++) begin
         d = DEP_P[k];
         chk($sformatf("core%0d", k), obs_core(k), hc[k][0]);
         for (int j = 0; j < NT_P[k] * NS_P[k]; j++)
            chk($sformatf("tap%0d_%0d", k, j), obs_tap(k, j), hc[k][d]);
         for (int b = 0; b < NT_P[k]; b++)
            chk($sformatf("wrap%0d_%0d", k, b), obs_wrap(k, b), hw[k][d]);
      end
   endtask

   task automatic cyc(input logic en, input logic cl);
      enable = en;
      clear  = cl;
      @(posedge clk);
      model_step(en, cl);
      #1;
      check_all();
   endtask

   // Assert reset between edges, check before any edge, hold across one edge
   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      enable = 1'b0;
      clear  = 1'b0;
      model_reset();
      #2;
      check_all();
      chk("rst_core_b", obs_core(1), 9);
      @(negedge clk);
      rst = 1'b0;

      repeat (12) cyc(1'b1, 1'b0);
      chk("run12_core_a", obs_core(0), 2);
      chk("run12_core_b", obs_core(1), 7);
      chk("run12_core_d", obs_core(3), 4);

      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      chk("hold_core_a", obs_core(0), 4);

      cyc(1'b1, 1'b0);
      chk("pre_clr_a", obs_core(0), 5);
      cyc(1'b1, 1'b1);
      chk("clr_core_a", obs_core(0), 0);
      chk("clr_tap_a", obs_tap(0, 0), 5);
      cyc(1'b0, 1'b0);
      chk("clr_tap_a2", obs_tap(0, 7), 0);
      chk("clr_wrap_a", obs_wrap(0, 0), 0);

      async_reset();
      repeat (37) cyc(1'b1, 1'b0);
      chk("core_c_37", obs_core(2), 37);
      chk("tap_c_34", obs_tap(2, 5), 34);
      async_reset();
      chk("rst_core_c", obs_core(2), 0);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(63) == 0) begin
            async_reset();
         end else begin
            cyc(($urandom_range(3) != 0), ($urandom_range(15) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
